inv_check: RTL

- Consumer-side checker for the extended-GCD block's results: (data_a, data_m, gcd, inv) → verdict.
- Computes prod = (data_a * inv) mod data_m with a bit-serial datapath: a restoring reduction of data_a, then an MSB-first interleaved modular multiply.
- Flags whether inv is a valid modular inverse, and whether that verdict agrees with the reported gcd.
- Sits downstream of exgcd in the gcd test harness / datapath, with valid/ready handshakes on both sides.

---
 rtl/exgcd_pkg.sv | 13 +
 rtl/mod_dbl_add.sv | 30 +++
 rtl/inv_check.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/exgcd_pkg.sv
// rtl/exgcd_pkg.sv - shared state type and default width for the exgcd/inv_check datapaths
package exgcd_pkg;

  localparam int GCD_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    MUL    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mod_dbl_add.sv
// rtl/mod_dbl_add.sv - one bit-serial modular step: shift-in/reduce or double-add-reduce
module mod_dbl_add
  import exgcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic [W:0]   r,
  input  logic [W:0]   rem,
  input  logic [W-1:0] m,
  input  logic         bit_in,
  input  logic         reduce,
  output logic [W:0]   r_next
);

  logic [W:0] m_ext;
  logic [W:0] t0;
  logic [W:0] t1;
  logic [W:0] t2;

  // r < m always holds on entry, so 2r (+1) and t1+rem both stay below 2m and fit in W+1 bits.
  // In reduce mode the incoming bit is shifted in and only the first compare/subtract applies.
  always_comb begin
    m_ext  = {1'b0, m};
    t0     = (r << 1) | {{W{1'b0}}, reduce & bit_in};
    t1     = (t0 >= m_ext) ? (t0 - m_ext) : t0;
    t2     = t1 + ((!reduce && bit_in) ? rem : '0);
    r_next = reduce ? t1 : ((t2 >= m_ext) ? (t2 - m_ext) : t2);
  end

endmodule

// File: rtl/inv_check.sv
// rtl/inv_check.sv - checks (a*inv) mod m == 1 against the reported gcd, bit-serially
module inv_check
  import exgcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_m,
  input  logic [W-1:0] gcd,
  input  logic [W-1:0] inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] prod,
  output logic         inv_ok,
  output logic         consistent,
  output logic         err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(W - 1);

  state_t state;
  state_t state_nx;

  logic [W-1:0]  a_q;
  logic [W-1:0]  m_q;
  logic [W-1:0]  g_q;
  logic [W-1:0]  inv_q;
  logic [W:0]    rem;
  logic [W:0]    r;
  logic [IW-1:0] i;

  logic          step_reduce;
  logic          step_bit;
  logic [W:0]    step_in;
  logic [W:0]    step_out;
  logic          ok_nx;
  logic          cons_nx;

  // A single step unit serves both phases: REDUCE feeds rem and a[i], MUL feeds r and inv[i].
  always_comb begin
    step_reduce = (state == REDUCE);
    step_in     = step_reduce ? rem : r;
    step_bit    = step_reduce ? a_q[i] : inv_q[i];
  end

  mod_dbl_add #(.W(W)) u_step (
    .r      (step_in),
    .rem    (rem),
    .m      (m_q),
    .bit_in (step_bit),
    .reduce (step_reduce),
    .r_next (step_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: each arithmetic phase runs W cycles counted by i.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = (data_m == '0) ? DONE : REDUCE;
      REDUCE:  if (i == '0) state_nx = MUL;
      MUL:     if (i == '0) state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Verdict values registered on the first DONE cycle; m==1 makes every inverse valid.
  always_comb begin
    ok_nx   = (m_q == W'(1)) ? 1'b1 : (r[W-1:0] == W'(1));
    cons_nx = ((g_q == W'(1)) == ok_nx);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      m_q        <= '0;
      g_q        <= '0;
      inv_q      <= '0;
      rem        <= '0;
      r          <= '0;
      i          <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      prod       <= '0;
      inv_ok     <= 1'b0;
      consistent <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q        <= data_a;
            m_q        <= data_m;
            g_q        <= gcd;
            inv_q      <= inv;
            rem        <= '0;
            r          <= '0;
            i          <= I_TOP;
            in_ready   <= 1'b0;
            prod       <= '0;
            inv_ok     <= 1'b0;
            consistent <= 1'b0;
            err        <= (data_m == '0);
          end
        end
        REDUCE: begin
          rem <= step_out;
          i   <= (i == '0) ? I_TOP : (i - 1'b1);
        end
        MUL: begin
          r <= step_out;
          i <= i - 1'b1;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (!err) begin
              prod       <= r[W-1:0];
              inv_ok     <= ok_nx;
              consistent <= cons_nx;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
